trisc_datapath: RTL and testbench
=================================

// Module: trisc_datapath
// PURPOSE
// - Responding end of the controller's control-word interface. Consumes the 15 control lines c0..c14
//   (c6 unused) and executes them against a single-bus accumulator datapath: PC, MAR, IR, ACC, ALU, 16x8 RAM.
// - Returns the IR opcode nibble (w,x,y,z) to the instruction decoder and the Z/N flags to the controller,
//   closing the fetch/decode/execute loop of the TRISC core.
// PARAMETERS
// - WORD_W  8  data/instruction width; instruction = {opcode[WORD_W-1:ADDR_W], addr[ADDR_W-1:0]}
// - ADDR_W  4  RAM address / PC width; RAM depth = 2**ADDR_W; opcode width WORD_W-ADDR_W must equal 4
// PORTS
// - clock     in   1       system clock, all state updates on rising edge
// - resetN    in   1       asynchronous active-low reset
// - ctrl      in   15      control word, bit i = ci (bit 6 ignored); encodings in trisc_pkg
// - loadEn    in   1       program-load write strobe (used while controller is stopped)
// - loadAddr  in   ADDR_W  program-load address
// - loadData  in   WORD_W  program-load data
// - w,x,y,z   out  1 each  IR[7],IR[6],IR[5],IR[4] -> instruction decoder
// - zFlag     out  1       ACC == 0 after last ACC update
// - nFlag     out  1       ACC[WORD_W-1] after last ACC update
// - accOut    out  WORD_W  ACC value
// - pcOut     out  ADDR_W  PC value
// - busError  out  1       sticky: more than one bus driver enabled in some cycle
// BEHAVIOUR
// - Control bits: c0 PCINC, c1 PCOUT, c2 MARLD, c3 RAMOUT, c4 IRLD, c5 IROUT, c7 ACCLD, c8 ACCOUT,
//   c9 RAMWR, c10 ALUOUT, c11/c12 ALUOP[1:0] (00 ADD, 01 SUB, 10 XOR, 11 INC), c13 ACCCLR, c14 PCLD.
// - Bus (combinational): PCOUT->{0,PC}; RAMOUT->RAM[MAR]; IROUT->{0,IR[3:0]}; ACCOUT->ACC; ALUOUT->ALU result.
//   No driver -> bus = 0. Several drivers -> bus = bitwise OR of drivers, busError set next edge, sticky until reset.
// - RAM: async read at MAR, sync write RAM[MAR] <= bus on RAMWR. loadEn writes RAM[loadAddr] <= loadData;
//   if loadEn and RAMWR coincide, loadEn wins and the RAMWR write is dropped. RAM contents are not reset.
// - ALU: A = ACC, B = RAM[MAR]; ADD A+B, SUB A-B, XOR A^B, INC A+1; results mod 2**WORD_W, carry discarded.
// - Register loads take effect on the edge where the bit is high; all observable outputs are 1-cycle latency.
// - PC: PCLD -> PC <= bus[ADDR_W-1:0]; else PCINC -> PC+1, wrapping 15->0. PCLD beats PCINC when both set.
//   Jump conditions (JPZ/JPN) are the controller's job; PCLD here is unconditional.
// - MAR <= bus[ADDR_W-1:0] on MARLD. IR <= bus on IRLD.
// - ACC: ACCCLR -> 0; else ACCLD -> bus. ACCCLR beats ACCLD.
// - Flags update only when ACC is written (CLR or LD), from the written value: Z = (val==0), N = val[MSB].
// - Loading a register while it drives the bus captures its own old value, e.g. PCOUT+PCLD leaves PC unchanged.
// - Reset (async, any time incl. mid-instruction): PC, MAR, IR, ACC = 0; zFlag = 1 (ACC==0); nFlag = 0;
//   busError = 0; w..z = 0. The control word is ignored while resetN is low.
// STRUCTURE
// - trisc_pkg: WORD_W/ADDR_W defaults, ctrl bit-index localparams (CTL_PCINC..CTL_PCLD), ALU op enum.
// - One sub-module: trisc_alu (pure combinational: A, B, op -> result).
// - Top level holds bus mux, driver-count check, registers and RAM array.
// TESTING
// - Reset mid-run: ACC=8'h55, PC=7, then pulse resetN low -> PC=0, ACC=0, IR=0, zFlag=1, nFlag=0, busError=0.
// - Fetch: load RAM[0]=8'h1A; PCOUT|MARLD; then RAMOUT|IRLD|PCINC -> {w,x,y,z}=4'b0001, pcOut=1.
// - ADD/N flag: ACC=8'h7F, MAR=4'hA, RAM[A]=8'h01; ALUOUT|ACCLD, op 00 -> accOut=8'h80, nFlag=1, zFlag=0.
// - SUB to zero and XOR: ACC=8'h3C, RAM[MAR]=8'h3C, op 01 -> accOut=0, zFlag=1; op 10 on 8'hF0^8'h0F -> 8'hFF.
// - PC priority/wrap: PC=4'hF, PCINC -> 0; IR=8'h93, IROUT|PCLD|PCINC -> pcOut=3. ACCCLR|ACCLD -> accOut=0.
// - Bus contention/load priority: PCOUT|ACCOUT in one cycle -> busError=1, stays 1 afterwards;
//   loadEn with RAMWR at MAR=loadAddr -> RAM holds loadData.

Source files
------------

// File: rtl/trisc_pkg.sv
// Shared widths, control-word bit positions and ALU operation encoding for the TRISC datapath.
package trisc_pkg;

  localparam int WORD_W = 8;
  localparam int ADDR_W = 4;
  localparam int CTL_W  = 15;

  localparam int CTL_PCINC    = 0;
  localparam int CTL_PCOUT    = 1;
  localparam int CTL_MARLD    = 2;
  localparam int CTL_RAMOUT   = 3;
  localparam int CTL_IRLD     = 4;
  localparam int CTL_IROUT    = 5;
  localparam int CTL_ACCLD    = 7;
  localparam int CTL_ACCOUT   = 8;
  localparam int CTL_RAMWR    = 9;
  localparam int CTL_ALUOUT   = 10;
  localparam int CTL_ALUOP_LO = 11;
  localparam int CTL_ALUOP_HI = 12;
  localparam int CTL_ACCCLR   = 13;
  localparam int CTL_PCLD     = 14;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_XOR = 2'b10,
    ALU_INC = 2'b11
  } alu_op_e;

  // True when two or more of the bus-enable bits are set.
  function automatic logic multi_driver(input logic [4:0] drv);
    return (drv & (drv - 5'd1)) != 5'd0;
  endfunction

endpackage

// File: rtl/trisc_if.sv
// Control-word / status interface between the TRISC controller (master) and datapath (slave).
interface trisc_if #(
  parameter int WORD_W = trisc_pkg::WORD_W,
  parameter int ADDR_W = trisc_pkg::ADDR_W
);
  logic [trisc_pkg::CTL_W-1:0] ctrl;
  logic                        loadEn;
  logic [ADDR_W-1:0]           loadAddr;
  logic [WORD_W-1:0]           loadData;
  logic                        w, x, y, z;
  logic                        zFlag;
  logic                        nFlag;
  logic [WORD_W-1:0]           accOut;
  logic [ADDR_W-1:0]           pcOut;
  logic                        busError;

  modport master (
    output ctrl, loadEn, loadAddr, loadData,
    input  w, x, y, z, zFlag, nFlag, accOut, pcOut, busError
  );

  modport slave (
    input  ctrl, loadEn, loadAddr, loadData,
    output w, x, y, z, zFlag, nFlag, accOut, pcOut, busError
  );
endinterface

// File: rtl/trisc_alu.sv
// Combinational ALU: A is the accumulator, B is the RAM word addressed by MAR.
module trisc_alu
  import trisc_pkg::*;
#(
  parameter int WORD_W = trisc_pkg::WORD_W
) (
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  input  alu_op_e           op_i,
  output logic [WORD_W-1:0] result_o
);

  always_comb begin
    result_o = '0;
    unique case (op_i)
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_XOR: result_o = a_i ^ b_i;
      ALU_INC: result_o = a_i + WORD_W'(1);
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/trisc_datapath.sv
// Single-bus accumulator datapath of the TRISC core: executes one control word per clock
// against PC, MAR, IR, ACC, ALU and a small RAM, returning opcode bits and flags.
module trisc_datapath #(
  parameter int WORD_W = trisc_pkg::WORD_W,
  parameter int ADDR_W = trisc_pkg::ADDR_W
) (
  input  logic    clock,
  input  logic    resetN,
  trisc_if.slave  dp
);
  import trisc_pkg::*;

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WORD_W-1:0] ram_q [DEPTH];

  logic [ADDR_W-1:0] pc_q,   pc_d;
  logic [ADDR_W-1:0] mar_q,  mar_d;
  logic [WORD_W-1:0] ir_q,   ir_d;
  logic [WORD_W-1:0] acc_q,  acc_d;
  logic              z_q,    z_d;
  logic              n_q,    n_d;
  logic              berr_q, berr_d;

  logic [WORD_W-1:0] bus;
  logic [WORD_W-1:0] ram_rd;
  logic [WORD_W-1:0] alu_res;
  logic [4:0]        drivers;
  logic              unused_ctrl6;

  assign unused_ctrl6 = dp.ctrl[6];
  assign ram_rd       = ram_q[mar_q];
  assign drivers      = {dp.ctrl[CTL_PCOUT], dp.ctrl[CTL_RAMOUT], dp.ctrl[CTL_IROUT],
                         dp.ctrl[CTL_ACCOUT], dp.ctrl[CTL_ALUOUT]};

  trisc_alu #(.WORD_W(WORD_W)) u_alu (
    .a_i      (acc_q),
    .b_i      (ram_rd),
    .op_i     (alu_op_e'(dp.ctrl[CTL_ALUOP_HI:CTL_ALUOP_LO])),
    .result_o (alu_res)
  );

  // Contending drivers are OR-ed rather than prioritised so a fault is visible on the bus value.
  always_comb begin
    bus = '0;
    if (dp.ctrl[CTL_PCOUT])  bus = bus | {{(WORD_W-ADDR_W){1'b0}}, pc_q};
    if (dp.ctrl[CTL_RAMOUT]) bus = bus | ram_rd;
    if (dp.ctrl[CTL_IROUT])  bus = bus | {{(WORD_W-ADDR_W){1'b0}}, ir_q[ADDR_W-1:0]};
    if (dp.ctrl[CTL_ACCOUT]) bus = bus | acc_q;
    if (dp.ctrl[CTL_ALUOUT]) bus = bus | alu_res;
  end

  always_comb begin
    pc_d   = pc_q;
    mar_d  = mar_q;
    ir_d   = ir_q;
    acc_d  = acc_q;
    z_d    = z_q;
    n_d    = n_q;
    berr_d = berr_q | multi_driver(drivers);

    if (dp.ctrl[CTL_PCLD])       pc_d = bus[ADDR_W-1:0];
    else if (dp.ctrl[CTL_PCINC]) pc_d = pc_q + ADDR_W'(1);

    if (dp.ctrl[CTL_MARLD]) mar_d = bus[ADDR_W-1:0];
    if (dp.ctrl[CTL_IRLD])  ir_d  = bus;

    if (dp.ctrl[CTL_ACCCLR])     acc_d = '0;
    else if (dp.ctrl[CTL_ACCLD]) acc_d = bus;

    // Flags track only ACC writes, so they reflect the last written value, not later bus traffic.
    if (dp.ctrl[CTL_ACCCLR] || dp.ctrl[CTL_ACCLD]) begin
      z_d = (acc_d == '0);
      n_d = acc_d[WORD_W-1];
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      pc_q   <= '0;
      mar_q  <= '0;
      ir_q   <= '0;
      acc_q  <= '0;
      z_q    <= 1'b1;
      n_q    <= 1'b0;
      berr_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      mar_q  <= mar_d;
      ir_q   <= ir_d;
      acc_q  <= acc_d;
      z_q    <= z_d;
      n_q    <= n_d;
      berr_q <= berr_d;
    end
  end

  // RAM holds its program across reset; the program-load port beats a datapath write.
  always_ff @(posedge clock) begin
    if (dp.loadEn)
      ram_q[dp.loadAddr] <= dp.loadData;
    else if (resetN && dp.ctrl[CTL_RAMWR])
      ram_q[mar_q] <= bus;
  end

  assign dp.w        = ir_q[WORD_W-1];
  assign dp.x        = ir_q[WORD_W-2];
  assign dp.y        = ir_q[WORD_W-3];
  assign dp.z        = ir_q[WORD_W-4];
  assign dp.zFlag    = z_q;
  assign dp.nFlag    = n_q;
  assign dp.accOut   = acc_q;
  assign dp.pcOut    = pc_q;
  assign dp.busError = berr_q;

endmodule

// File: tb/tb_trisc_datapath.sv
// Directed bench for trisc_datapath: drives control words through the interface and checks outputs.
module tb_trisc_datapath;

  localparam logic [14:0] C_PCINC  = 15'h0001;
  localparam logic [14:0] C_PCOUT  = 15'h0002;
  localparam logic [14:0] C_MARLD  = 15'h0004;
  localparam logic [14:0] C_RAMOUT = 15'h0008;
  localparam logic [14:0] C_IRLD   = 15'h0010;
  localparam logic [14:0] C_IROUT  = 15'h0020;
  localparam logic [14:0] C_ACCLD  = 15'h0080;
  localparam logic [14:0] C_ACCOUT = 15'h0100;
  localparam logic [14:0] C_RAMWR  = 15'h0200;
  localparam logic [14:0] C_ALUOUT = 15'h0400;
  localparam logic [14:0] OP_SUB   = 15'h0800;
  localparam logic [14:0] OP_XOR   = 15'h1000;
  localparam logic [14:0] OP_INC   = 15'h1800;
  localparam logic [14:0] C_ACCCLR = 15'h2000;
  localparam logic [14:0] C_PCLD   = 15'h4000;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  trisc_if #(.WORD_W(8), .ADDR_W(4)) dif ();

  trisc_datapath #(.WORD_W(8), .ADDR_W(4)) dut (
    .clock  (clk),
    .resetN (rst_n),
    .dp     (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [14:0] cw);
    @(negedge clk);
    dif.ctrl = cw;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    dif.ctrl     = '0;
    dif.loadEn   = 1'b1;
    dif.loadAddr = a;
    dif.loadData = d;
    @(posedge clk);
    #1;
    dif.loadEn = 1'b0;
  endtask

  // Empty bus clears MAR, then RAM[0] is used as a scratch word holding the target address.
  task automatic set_mar(input logic [3:0] a);
    step(C_MARLD);
    load(4'h0, {4'h0, a});
    step(C_RAMOUT | C_MARLD);
  endtask

  task automatic set_acc(input logic [7:0] v);
    set_mar(4'h5);
    load(4'h5, v);
    step(C_RAMOUT | C_ACCLD);
  endtask

  task automatic set_pc(input logic [3:0] p);
    set_mar(4'hE);
    load(4'hE, {4'h0, p});
    step(C_RAMOUT | C_PCLD);
  endtask

  function automatic logic [3:0] wxyz();
    return {dif.w, dif.x, dif.y, dif.z};
  endfunction

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    dif.ctrl     = '0;
    dif.loadEn   = 1'b0;
    dif.loadAddr = '0;
    dif.loadData = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    chk("rst_pc", 32'(dif.pcOut), 32'h0);
    chk("rst_acc", 32'(dif.accOut), 32'h0);
    chk("rst_z", 32'(dif.zFlag), 32'h1);
    chk("rst_n", 32'(dif.nFlag), 32'h0);
    chk("rst_berr", 32'(dif.busError), 32'h0);
    chk("rst_wxyz", 32'(wxyz()), 32'h0);

    // Mid-run asynchronous reset
    set_acc(8'h55);
    set_pc(4'h7);
    set_mar(4'h3);
    load(4'h3, 8'hC5);
    step(C_RAMOUT | C_IRLD);
    chk("pre_acc", 32'(dif.accOut), 32'h55);
    chk("pre_pc", 32'(dif.pcOut), 32'h7);
    chk("pre_wxyz", 32'(wxyz()), 32'hC);
    chk("pre_z", 32'(dif.zFlag), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_pc", 32'(dif.pcOut), 32'h0);
    chk("mid_rst_acc", 32'(dif.accOut), 32'h0);
    chk("mid_rst_wxyz", 32'(wxyz()), 32'h0);
    chk("mid_rst_z", 32'(dif.zFlag), 32'h1);
    chk("mid_rst_n", 32'(dif.nFlag), 32'h0);
    chk("mid_rst_berr", 32'(dif.busError), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fetch
    load(4'h0, 8'h1A);
    step(C_PCOUT | C_MARLD);
    step(C_RAMOUT | C_IRLD | C_PCINC);
    chk("fetch_wxyz", 32'(wxyz()), 32'h1);
    chk("fetch_pc", 32'(dif.pcOut), 32'h1);
    step(C_IROUT | C_ACCLD);
    chk("irout_acc", 32'(dif.accOut), 32'h0A);

    // ADD into sign bit
    set_acc(8'h7F);
    set_mar(4'hA);
    load(4'hA, 8'h01);
    step(C_ALUOUT | C_ACCLD);
    chk("add_acc", 32'(dif.accOut), 32'h80);
    chk("add_n", 32'(dif.nFlag), 32'h1);
    chk("add_z", 32'(dif.zFlag), 32'h0);

    // SUB to zero
    set_acc(8'h3C);
    set_mar(4'hB);
    load(4'hB, 8'h3C);
    step(C_ALUOUT | C_ACCLD | OP_SUB);
    chk("sub_acc", 32'(dif.accOut), 32'h00);
    chk("sub_z", 32'(dif.zFlag), 32'h1);
    chk("sub_n", 32'(dif.nFlag), 32'h0);

    // XOR then INC with wrap
    set_acc(8'hF0);
    set_mar(4'hC);
    load(4'hC, 8'h0F);
    step(C_ALUOUT | C_ACCLD | OP_XOR);
    chk("xor_acc", 32'(dif.accOut), 32'hFF);
    chk("xor_n", 32'(dif.nFlag), 32'h1);
    step(C_ALUOUT | C_ACCLD | OP_INC);
    chk("inc_acc", 32'(dif.accOut), 32'h00);
    chk("inc_z", 32'(dif.zFlag), 32'h1);

    // PC wrap and priorities
    set_pc(4'hF);
    step(C_PCINC);
    chk("pc_wrap", 32'(dif.pcOut), 32'h0);
    set_mar(4'hD);
    load(4'hD, 8'h93);
    step(C_RAMOUT | C_IRLD);
    chk("ir93_wxyz", 32'(wxyz()), 32'h9);
    step(C_IROUT | C_PCLD | C_PCINC);
    chk("pcld_prio", 32'(dif.pcOut), 32'h3);
    step(C_PCOUT | C_PCLD);
    chk("pc_self_ld", 32'(dif.pcOut), 32'h3);
    set_acc(8'h42);
    step(C_ACCCLR | C_ACCLD | C_RAMOUT);
    chk("clr_prio_acc", 32'(dif.accOut), 32'h00);
    chk("clr_prio_z", 32'(dif.zFlag), 32'h1);
    chk("no_berr", 32'(dif.busError), 32'h0);

    // RAM write from bus
    set_acc(8'h66);
    set_mar(4'h6);
    step(C_ACCOUT | C_RAMWR);
    step(C_ACCCLR);
    step(C_RAMOUT | C_ACCLD);
    chk("ramwr_acc", 32'(dif.accOut), 32'h66);

    // Bus contention: OR of drivers, sticky error
    step(C_PCOUT | C_ACCOUT | C_ACCLD);
    chk("cont_acc", 32'(dif.accOut), 32'h67);
    chk("cont_berr", 32'(dif.busError), 32'h1);
    step(15'h0000);
    chk("berr_sticky", 32'(dif.busError), 32'h1);

    // loadEn beats RAMWR at the same address
    @(negedge clk);
    dif.ctrl     = C_ACCOUT | C_RAMWR;
    dif.loadEn   = 1'b1;
    dif.loadAddr = 4'h6;
    dif.loadData = 8'hA5;
    @(posedge clk);
    #1;
    dif.loadEn = 1'b0;
    step(C_RAMOUT | C_ACCLD);
    chk("load_prio", 32'(dif.accOut), 32'hA5);
    chk("berr_still", 32'(dif.busError), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
